// File: rtl/ysyx_25060173_isa_pkg.sv
// RV32I/RV32M decode constants shared by the decode stage and the EXU.
// Instruction classes are one-hot bit positions given by cls_e.
package ysyx_25060173_isa_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_OP_IMM,
        CLS_OP,
        CLS_MULDIV,
        CLS_SYSTEM,
        CLS_COUNT
    } cls_e;

    localparam int NCLS = int'(CLS_COUNT);

    // Classes that write rd back to the register file
    localparam logic [NCLS-1:0] CLS_WB_MASK = NCLS'((1 << CLS_LUI) | (1 << CLS_AUIPC) |
                                                    (1 << CLS_JAL) | (1 << CLS_JALR) |
                                                    (1 << CLS_LOAD) | (1 << CLS_OP_IMM) |
                                                    (1 << CLS_OP) | (1 << CLS_MULDIV));

    localparam logic [2:0] F3_JALR     = 3'b000;
    localparam logic [2:0] F3_ADD      = 3'b000;
    localparam logic [2:0] F3_SLL      = 3'b001;
    localparam logic [2:0] F3_SR       = 3'b101;
    localparam logic [2:0] F3_BR_RSV0  = 3'b010;
    localparam logic [2:0] F3_BR_RSV1  = 3'b011;
    localparam logic [2:0] F3_LD_RSV0  = 3'b011;
    localparam logic [2:0] F3_LD_RSV1  = 3'b110;
    localparam logic [2:0] F3_LD_RSV2  = 3'b111;
    localparam logic [2:0] F3_ST_MAX   = 3'b010;

    localparam logic [6:0] F7_BASE     = 7'b0000000;
    localparam logic [6:0] F7_ALT      = 7'b0100000;
    localparam logic [6:0] F7_MULDIV   = 7'b0000001;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

    typedef struct packed {
        logic [NCLS-1:0] cls;
        logic [2:0]      funct3;
        logic            alt;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rf_wen;
        logic            illegal;
        logic            ebreak;
        logic            ecall;
    } dec_t;

    typedef enum logic [1:0] {
        SK_EMPTY,
        SK_ONE,
        SK_TWO
    } skid_e;

endpackage

// File: rtl/ysyx_25060173_decode_stage_if.sv
// IFU->decode and decode->EXU handshake bundle.
// slave is the decode stage; master is the surrounding pipeline (IFU + EXU).
interface ysyx_25060173_decode_stage_if
    import ysyx_25060173_isa_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [NCLS-1:0] out_cls;
    logic [2:0]      out_funct3;
    logic            out_alt;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_rf_wen;
    logic            out_illegal;
    logic            out_ebreak;
    logic            out_ecall;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready,
        output out_valid, out_pc, out_cls, out_funct3, out_alt, out_rs1, out_rs2,
               out_rd, out_imm, out_rf_wen, out_illegal, out_ebreak, out_ecall
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready,
        input  out_valid, out_pc, out_cls, out_funct3, out_alt, out_rs1, out_rs2,
               out_rd, out_imm, out_rf_wen, out_illegal, out_ebreak, out_ecall
    );

endinterface

// File: rtl/ysyx_25060173_imm_gen.sv
// Combinational RV32 immediate generator selected by one-hot class.
// Shared between the decode stage and the EXU.
module ysyx_25060173_imm_gen
    import ysyx_25060173_isa_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]             inst,
    input  logic [NCLS-1:0]         cls,
    output logic signed [XLEN-1:0]  imm
);

    // R-type classes carry no immediate
    logic unused_cls;
    assign unused_cls = cls[CLS_OP] | cls[CLS_MULDIV];

    always_comb begin
        imm = '0;
        if (cls[CLS_OP_IMM] | cls[CLS_LOAD] | cls[CLS_JALR] | cls[CLS_SYSTEM]) begin
            imm = XLEN'($signed(inst[31:20]));
        end else if (cls[CLS_STORE]) begin
            imm = XLEN'($signed({inst[31:25], inst[11:7]}));
        end else if (cls[CLS_BRANCH]) begin
            imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        end else if (cls[CLS_LUI] | cls[CLS_AUIPC]) begin
            imm = XLEN'($signed({inst[31:12], 12'b0}));
        end else if (cls[CLS_JAL]) begin
            imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        end
    end

endmodule

// File: rtl/ysyx_25060173_decode_stage.sv
// Registered RV32I(+M) decode stage between IFU and EXU with valid/ready on
// both sides, optional 2-entry skid buffer, and flush for redirects.
module ysyx_25060173_decode_stage
    import ysyx_25060173_isa_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PC_W     = 32,
    parameter int RV32M_EN = 0,
    parameter int SKID_EN  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    ysyx_25060173_decode_stage_if.slave bus
);

    typedef struct packed {
        dec_t            dec;
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] imm;
    } beat_t;

    logic [31:0]            inst_p0;
    logic [6:0]             opcode_p0;
    logic [2:0]             funct3_p0;
    logic [6:0]             funct7_p0;
    cls_e                   cls_idx_p0;
    logic                   legal_p0;
    logic [NCLS-1:0]        cls_oh_p0;
    logic signed [XLEN-1:0] imm_p0;
    dec_t                   dec_p0;
    beat_t                  beat_p0;

    beat_t                  out_p1;
    beat_t                  skid_p1;
    logic                   vld_p1;
    logic                   rdy_p1;
    skid_e                  state_p1;

    logic                   accept;
    logic                   drain;

    // ---- stage 0: combinational decode of the incoming instruction ----
    assign inst_p0   = bus.in_inst;
    assign opcode_p0 = inst_p0[6:0];
    assign funct3_p0 = inst_p0[14:12];
    assign funct7_p0 = inst_p0[31:25];

    always_comb begin
        cls_idx_p0 = CLS_LUI;
        legal_p0   = 1'b0;
        case (opcode_p0)
            OPC_LUI:    begin cls_idx_p0 = CLS_LUI;   legal_p0 = 1'b1; end
            OPC_AUIPC:  begin cls_idx_p0 = CLS_AUIPC; legal_p0 = 1'b1; end
            OPC_JAL:    begin cls_idx_p0 = CLS_JAL;   legal_p0 = 1'b1; end
            OPC_JALR: begin
                cls_idx_p0 = CLS_JALR;
                legal_p0   = (funct3_p0 == F3_JALR);
            end
            OPC_BRANCH: begin
                cls_idx_p0 = CLS_BRANCH;
                legal_p0   = (funct3_p0 != F3_BR_RSV0) && (funct3_p0 != F3_BR_RSV1);
            end
            OPC_LOAD: begin
                cls_idx_p0 = CLS_LOAD;
                legal_p0   = (funct3_p0 != F3_LD_RSV0) && (funct3_p0 != F3_LD_RSV1) &&
                             (funct3_p0 != F3_LD_RSV2);
            end
            OPC_STORE: begin
                cls_idx_p0 = CLS_STORE;
                legal_p0   = (funct3_p0 <= F3_ST_MAX);
            end
            OPC_OP_IMM: begin
                cls_idx_p0 = CLS_OP_IMM;
                // Only shifts constrain funct7; SLLI has no arithmetic variant
                case (funct3_p0)
                    F3_SLL:  legal_p0 = (funct7_p0 == F7_BASE);
                    F3_SR:   legal_p0 = (funct7_p0 == F7_BASE) || (funct7_p0 == F7_ALT);
                    default: legal_p0 = 1'b1;
                endcase
            end
            OPC_OP: begin
                cls_idx_p0 = CLS_OP;
                if (funct7_p0 == F7_BASE) begin
                    legal_p0 = 1'b1;
                end else if (funct7_p0 == F7_ALT) begin
                    legal_p0 = (funct3_p0 == F3_ADD) || (funct3_p0 == F3_SR);
                end else if (funct7_p0 == F7_MULDIV) begin
                    cls_idx_p0 = CLS_MULDIV;
                    legal_p0   = (RV32M_EN != 0);
                end
            end
            OPC_SYSTEM: begin
                cls_idx_p0 = CLS_SYSTEM;
                legal_p0   = (inst_p0 == INST_ECALL) || (inst_p0 == INST_EBREAK);
            end
            default: legal_p0 = 1'b0;
        endcase
    end

    // Illegal beats carry no class, which also zeroes imm and rf_wen
    assign cls_oh_p0 = legal_p0 ? (NCLS'(1) << cls_idx_p0) : '0;

    ysyx_25060173_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .inst (inst_p0[31:7]),
        .cls  (cls_oh_p0),
        .imm  (imm_p0)
    );

    always_comb begin
        dec_p0.cls     = cls_oh_p0;
        dec_p0.funct3  = funct3_p0;
        dec_p0.alt     = inst_p0[30];
        dec_p0.rs1     = inst_p0[19:15];
        dec_p0.rs2     = inst_p0[24:20];
        dec_p0.rd      = inst_p0[11:7];
        dec_p0.rf_wen  = (|(cls_oh_p0 & CLS_WB_MASK)) && (inst_p0[11:7] != 5'd0);
        dec_p0.illegal = ~legal_p0;
        dec_p0.ebreak  = (inst_p0 == INST_EBREAK);
        dec_p0.ecall   = (inst_p0 == INST_ECALL);
        beat_p0.dec    = dec_p0;
        beat_p0.pc     = bus.in_pc;
        beat_p0.imm    = imm_p0;
    end

    // ---- stage 1: output register plus skid entry ----
    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = vld_p1 & bus.out_ready;

    // Without the skid entry, ONE+accept always coincides with drain, so SK_TWO is unreachable
    assign bus.in_ready = (SKID_EN != 0) ? rdy_p1 : (~vld_p1 | bus.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= SK_EMPTY;
            vld_p1   <= 1'b0;
            rdy_p1   <= 1'b1;
            out_p1   <= '0;
            skid_p1  <= '0;
        end else if (flush) begin
            state_p1 <= SK_EMPTY;
            vld_p1   <= 1'b0;
            rdy_p1   <= 1'b1;
        end else begin
            case (state_p1)
                SK_EMPTY: begin
                    if (accept) begin
                        out_p1   <= beat_p0;
                        vld_p1   <= 1'b1;
                        state_p1 <= SK_ONE;
                    end
                end
                SK_ONE: begin
                    if (accept && drain) begin
                        out_p1 <= beat_p0;
                    end else if (accept) begin
                        skid_p1  <= beat_p0;
                        rdy_p1   <= 1'b0;
                        state_p1 <= SK_TWO;
                    end else if (drain) begin
                        vld_p1   <= 1'b0;
                        state_p1 <= SK_EMPTY;
                    end
                end
                SK_TWO: begin
                    if (drain) begin
                        out_p1   <= skid_p1;
                        rdy_p1   <= 1'b1;
                        state_p1 <= SK_ONE;
                    end
                end
                default: begin
                    vld_p1   <= 1'b0;
                    rdy_p1   <= 1'b1;
                    state_p1 <= SK_EMPTY;
                end
            endcase
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.out_pc      = out_p1.pc;
    assign bus.out_cls     = out_p1.dec.cls;
    assign bus.out_funct3  = out_p1.dec.funct3;
    assign bus.out_alt     = out_p1.dec.alt;
    assign bus.out_rs1     = out_p1.dec.rs1;
    assign bus.out_rs2     = out_p1.dec.rs2;
    assign bus.out_rd      = out_p1.dec.rd;
    assign bus.out_imm     = out_p1.imm;
    assign bus.out_rf_wen  = out_p1.dec.rf_wen;
    assign bus.out_illegal = out_p1.dec.illegal;
    assign bus.out_ebreak  = out_p1.dec.ebreak;
    assign bus.out_ecall   = out_p1.dec.ecall;

endmodule

// File: doc/ysyx_25060173_decode_stage.md
Name: ysyx_25060173_decode_stage

Overview:
Registered RV32I decode stage between IFU and EXU, replacing the flat per-instruction decode flags with a complete RV32I class decode plus an optional RV32M extension. It decodes all register and immediate fields and sign-extends the immediate. It also flags illegal encodings. The stage uses valid/ready handshakes on both sides, with an optional 2-entry skid buffer for full throughput, and supports a flush for redirects.

Parameters:
XLEN, 32, datapath/immediate width (32 only supported; 64 reserved)
PC_W, 32, PC width
RV32M_EN, 0, 1 = accept OP-class funct7=0000001 (MUL/DIV group) as legal
SKID_EN, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single register

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  drop all held and incoming beats
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept
in_inst  in  32  raw instruction
in_pc  in  PC_W  instruction PC
out_valid  out  1  decoded beat valid
out_ready  in  1  downstream accepts
out_pc  out  PC_W  PC passthrough
out_cls  out  NCLS  one-hot class: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MULDIV, SYSTEM
out_funct3  out  3  inst[14:12]
out_alt  out  1  inst[30] (SUB/SRA select)
out_rs1, out_rs2, out_rd  out  5 each  register indices
out_imm  out  XLEN  sign-extended immediate
out_rf_wen  out  1  writes rd
out_illegal  out  1  illegal encoding
out_ebreak  out  1  inst == 0x00100073
out_ecall  out  1  inst == 0x00000073

Behaviour:
- Reset (async, rst_n=0): out_valid=0; in_ready=1; all data outputs 0; both skid entries empty.
- Decode is combinational on in_inst. The result is registered on accept (in_valid & in_ready). Latency is 1 cycle: out_valid rises the cycle after accept.
- Handshake: a beat transfers on valid & ready. out_* stay stable while out_valid & ~out_ready. out_valid must not drop without a transfer or a flush.
- SKID_EN=1: states EMPTY, ONE, TWO. in_ready is a register, equal to (state != TWO).
  - EMPTY: accept goes to ONE.
  - ONE: accept with no drain goes to TWO. Drain with no accept goes to EMPTY. Accept and drain together stay in ONE.
  - TWO: drain goes to ONE, and the skid entry moves to the output.
  - Order is strictly FIFO.
  - Sustained in_valid & out_ready gives 1 beat/cycle.
- SKID_EN=0: in_ready = ~out_valid | out_ready (combinational).
- Flush has priority over everything. On the next edge: out_valid=0, all entries empty, in_ready=1. A beat offered in the flush cycle is discarded.
- Immediate by class:
  - I (OP_IMM, LOAD, JALR, SYSTEM): inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All immediates are sign-extended from inst[31]. Other classes use imm=0.
- out_rf_wen = class in {LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, MULDIV} & rd != 0 & ~illegal.
- out_rs2 = inst[24:20] and out_rd = inst[11:7] regardless of class. Consumers qualify them by class.
- Illegal when any of the following holds:
  - inst[1:0] != 11, or the opcode is unknown.
  - JALR funct3 != 0.
  - BRANCH funct3 in {010, 011}.
  - LOAD funct3 in {011, 110, 111}.
  - STORE funct3 > 010.
  - OP_IMM shifts (funct3 001/101) with funct7 not in {0000000, 0100000}, or funct3=001 with inst[30]=1.
  - OP funct7 not in {0000000, 0100000 (funct3 000/101 only)}, with 0000001 allowed only when RV32M_EN=1.
  - SYSTEM other than ecall/ebreak.
- An illegal beat is still delivered with out_illegal=1, out_cls=0, out_rf_wen=0, ebreak=ecall=0. It is never dropped.

Decomposition:
- Package ysyx_25060173_isa_pkg holds:
  - opcode constants;
  - the class index enum, with NCLS derived from it;
  - funct3/funct7 constants;
  - ebreak/ecall encodings.
- Sub-module ysyx_25060173_imm_gen is combinational (inst, class to imm) and is reused later by the EXU.
- Skid storage is inline in the stage.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready=1: 1 cycle later out_cls=OP_IMM, rd=1, imm=5, rf_wen=1, illegal=0.
- sw x2,8(x1) (0x0020A423): STORE, rs1=1, rs2=2, imm=8, rf_wen=0. lui x5,0x12345 (0x123452B7): imm=0x12345000. jal x1,-4 (0xFFDFF0EF): imm=0xFFFFFFFC.
- ebreak 0x00100073: out_ebreak=1, SYSTEM, illegal=0. 0x00200073: illegal=1.
- mul x3,x1,x2 (0x022081B3): with RV32M_EN=0, illegal=1 and rf_wen=0. With RV32M_EN=1, MULDIV and rf_wen=1.
- SKID_EN=1, stream 8 beats, out_ready low for 3 cycles mid-stream:
  - in_ready drops only after 2 beats are held;
  - output order matches input order, with no loss or duplication;
  - throughput returns to 1/cycle after out_ready rises.
- Hold 2 beats, assert flush with in_valid=1: next cycle out_valid=0, in_ready=1, and no flushed PC ever appears at the output. Deassert rst_n mid-stream: out_valid=0 immediately (async).
